// File: rtl/hash_node_ctrl.sv
// Ring-attached hash node: gathers ring words into a block, hands blocks to a
// chaining hash core, and streams the final digest back onto the ring MSW first.
module hash_node_ctrl #(
  parameter int unsigned ring_width_p   = 32,
  parameter int unsigned msg_width_p    = 512,
  parameter int unsigned digest_width_p = 256,
  parameter int unsigned id_p           = 0
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      en_i,

  input  logic                      v_i,
  input  logic [ring_width_p-1:0]   data_i,
  input  logic                      last_i,
  output logic                      ready_o,

  output logic                      v_o,
  output logic [ring_width_p-1:0]   data_o,
  input  logic                      yumi_i,

  output logic                      core_v_o,
  output logic [msg_width_p-1:0]    core_msg_o,
  output logic                      core_first_o,
  input  logic                      core_ready_i,

  input  logic                      core_v_i,
  input  logic [digest_width_p-1:0] core_digest_i,
  output logic                      core_yumi_o
);

  localparam int unsigned MW   = msg_width_p / ring_width_p;
  localparam int unsigned DW   = digest_width_p / ring_width_p;
  localparam int unsigned MaxW = (MW > DW) ? MW : DW;
  localparam int unsigned CW   = (MaxW > 1) ? $clog2(MaxW) : 1;

  typedef enum logic [1:0] {
    FILL,
    ISSUE,
    BUSY,
    DRAIN
  } state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [msg_width_p-1:0]    blk_q, blk_d;
  logic [digest_width_p-1:0] dig_q, dig_d;
  logic                      first_q, first_d;
  logic                      last_q, last_d;

  logic accept;
  logic issue;

  // ready is also held low during reset even though the state register
  // already reads FILL, so nothing can be handed over while reset is asserted
  assign ready_o      = en_i & ~reset_i & (state_q == FILL);
  assign accept       = ready_o & v_i;
  assign core_v_o     = en_i & (state_q == ISSUE);
  assign issue        = core_v_o & core_ready_i;
  assign core_yumi_o  = (state_q == BUSY) & core_v_i;
  assign core_msg_o   = blk_q;
  assign core_first_o = first_q;
  assign v_o          = (state_q == DRAIN);
  assign data_o       = dig_q[digest_width_p-1 -: ring_width_p];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    dig_d   = dig_q;
    first_d = first_q;
    last_d  = last_q;

    unique case (state_q)
      FILL: begin
        if (accept) begin
          // shift-and-or form stays valid even when a block is a single word
          blk_d = (blk_q << ring_width_p) | msg_width_p'(data_i);
          if (cnt_q == CW'(MW - 1)) begin
            last_d  = last_i;
            cnt_d   = '0;
            state_d = ISSUE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ISSUE: begin
        if (issue) begin
          state_d = BUSY;
        end
      end

      BUSY: begin
        if (core_v_i) begin
          if (last_q) begin
            dig_d   = core_digest_i;
            first_d = 1'b1;
            state_d = DRAIN;
          end else begin
            first_d = 1'b0;
            state_d = FILL;
          end
        end
      end

      DRAIN: begin
        if (yumi_i) begin
          dig_d = dig_q << ring_width_p;
          if (cnt_q == CW'(DW - 1)) begin
            cnt_d   = '0;
            state_d = FILL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= FILL;
      cnt_q   <= '0;
      blk_q   <= '0;
      dig_q   <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      dig_q   <= dig_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_hash_node_ctrl.sv
// Directed bench for hash_node_ctrl: table-driven fill vectors plus
// hand-written issue/busy/drain sequences against a scripted core.
module tb_hash_node_ctrl;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         en_i;
  logic         v_i;
  logic [31:0]  data_i;
  logic         last_i;
  logic         ready_o;
  logic         v_o;
  logic [31:0]  data_o;
  logic         yumi_i;
  logic         core_v_o;
  logic [511:0] core_msg_o;
  logic         core_first_o;
  logic         core_ready_i;
  logic         core_v_i;
  logic [255:0] core_digest_i;
  logic         core_yumi_o;

  int total = 0;
  int bad   = 0;
  int yumi_cnt = 0;
  int out_cnt  = 0;

  always #5 clk = ~clk;

  hash_node_ctrl #(
    .ring_width_p   (32),
    .msg_width_p    (512),
    .digest_width_p (256),
    .id_p           (3)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .en_i          (en_i),
    .v_i           (v_i),
    .data_i        (data_i),
    .last_i        (last_i),
    .ready_o       (ready_o),
    .v_o           (v_o),
    .data_o        (data_o),
    .yumi_i        (yumi_i),
    .core_v_o      (core_v_o),
    .core_msg_o    (core_msg_o),
    .core_first_o  (core_first_o),
    .core_ready_i  (core_ready_i),
    .core_v_i      (core_v_i),
    .core_digest_i (core_digest_i),
    .core_yumi_o   (core_yumi_o)
  );

  always @(posedge clk) begin
    if (core_yumi_o) yumi_cnt++;
    if (v_o && yumi_i) out_cnt++;
  end

  typedef struct {
    logic        en;
    logic        v;
    logic [31:0] d;
    logic        last;
    logic        exp_ready;
  } vec_t;

  vec_t tbl[36];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input int i);
    en_i   = tbl[i].en;
    v_i    = tbl[i].v;
    data_i = tbl[i].d;
    last_i = tbl[i].last;
    #2;
    chk("vec_ready", ready_o, tbl[i].exp_ready);
    chk("vec_core_v", core_v_o, 1'b0);
    cyc();
    v_i    = 1'b0;
    last_i = 1'b0;
    en_i   = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    v_i    = 1'b1;
    data_i = d;
    last_i = l;
    #2;
    chk("fill_ready", ready_o, 1'b1);
    cyc();
    v_i    = 1'b0;
    last_i = 1'b0;
  endtask

  task automatic issue(input logic [511:0] msg, input logic first, input int stall);
    #2;
    chk("issue_core_v", core_v_o, 1'b1);
    chk("issue_msg", core_msg_o, msg);
    chk("issue_first", core_first_o, first);
    chk("issue_ready", ready_o, 1'b0);
    for (int s = 0; s < stall; s++) begin
      cyc();
      #2;
      chk("stall_core_v", core_v_o, 1'b1);
      chk("stall_msg", core_msg_o, msg);
    end
    core_ready_i = 1'b1;
    cyc();
    core_ready_i = 1'b0;
  endtask

  task automatic respond(input logic [255:0] dig, input int delay);
    for (int s = 0; s < delay; s++) begin
      #2;
      chk("busy_yumi_idle", core_yumi_o, 1'b0);
      chk("busy_core_v", core_v_o, 1'b0);
      chk("busy_ready", ready_o, 1'b0);
      cyc();
    end
    core_v_i      = 1'b1;
    core_digest_i = dig;
    #2;
    chk("busy_yumi", core_yumi_o, 1'b1);
    cyc();
    core_v_i      = 1'b0;
    core_digest_i = '0;
  endtask

  task automatic drain(input logic [255:0] dig, input logic gap);
    logic [31:0] w;
    for (int i = 0; i < 8; i++) begin
      w = dig[255 - 32*i -: 32];
      if (gap) begin
        yumi_i = 1'b0;
        #2;
        chk("drain_hold_v", v_o, 1'b1);
        chk("drain_hold_data", data_o, w);
        chk("drain_ready", ready_o, 1'b0);
        cyc();
      end
      yumi_i = 1'b1;
      #2;
      chk("drain_v", v_o, 1'b1);
      chk("drain_data", data_o, w);
      cyc();
      yumi_i = 1'b0;
    end
    #2;
    chk("drain_done_v", v_o, 1'b0);
    chk("drain_done_ready", ready_o, 1'b1);
  endtask

  logic [511:0] msg;
  logic [255:0] dig_abc, dig_a, dig_b;
  logic [31:0]  w;
  int           y0, o0;

  initial begin
    dig_abc = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    dig_a   = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
    dig_b   = 256'h0badf00d_deadbeef_cafef00d_12345678_9abcdef0_0f1e2d3c_4b5a6978_a5a5a5a5;

    for (int i = 0; i < 16; i++) begin
      tbl[i].en        = 1'b1;
      tbl[i].v         = 1'b1;
      tbl[i].d         = (i == 0) ? 32'h61626380 : ((i == 15) ? 32'h00000018 : 32'h0);
      tbl[i].last      = (i == 15);
      tbl[i].exp_ready = 1'b1;
    end
    for (int k = 0; k < 20; k++) begin
      tbl[16+k].v = 1'b1;
      if (k < 7) begin
        tbl[16+k].en = 1'b1; tbl[16+k].d = 32'hA0000000 + k;
        tbl[16+k].last = 1'b0; tbl[16+k].exp_ready = 1'b1;
      end else if (k < 11) begin
        tbl[16+k].en = 1'b0; tbl[16+k].d = 32'hBAD00000 + k;
        tbl[16+k].last = 1'b1; tbl[16+k].exp_ready = 1'b0;
      end else begin
        tbl[16+k].en = 1'b1; tbl[16+k].d = 32'hA0000000 + (k - 4);
        tbl[16+k].last = (k == 19); tbl[16+k].exp_ready = 1'b1;
      end
    end

    reset_i = 1'b1; en_i = 1'b1; v_i = 1'b1; data_i = 32'hFFFFFFFF; last_i = 1'b1;
    yumi_i = 1'b0; core_ready_i = 1'b1; core_v_i = 1'b1; core_digest_i = '1;
    #2;
    chk("rst_ready", ready_o, 1'b0);
    chk("rst_v_o", v_o, 1'b0);
    chk("rst_core_v", core_v_o, 1'b0);
    chk("rst_core_yumi", core_yumi_o, 1'b0);
    chk("rst_msg", core_msg_o, '0);
    chk("rst_first", core_first_o, 1'b1);
    cyc(); cyc();
    reset_i = 1'b0; v_i = 1'b0; last_i = 1'b0;
    core_ready_i = 1'b0; core_v_i = 1'b0; core_digest_i = '0;
    #2;
    chk("post_rst_ready", ready_o, 1'b1);
    chk("post_rst_msg", core_msg_o, '0);
    cyc();

    // V-1: single-block "abc" message
    msg = '0;
    for (int i = 0; i < 16; i++) begin
      apply_vec(i);
      msg = (msg << 32) | 512'(tbl[i].d);
    end
    issue(msg, 1'b1, 0);
    respond(dig_abc, 2);
    #2;
    chk("v1_latency_v_o", v_o, 1'b1);
    chk("v1_first_word", data_o, 32'hba7816bf);
    cyc();
    drain(dig_abc, 1'b0);
    cyc();

    // V-2: two-block message; stray last_i on a middle word must be ignored
    y0 = yumi_cnt; o0 = out_cnt;
    msg = '0;
    for (int i = 0; i < 16; i++) begin
      w = 32'h10000000 + i;
      send_word(w, (i == 4));
      msg = (msg << 32) | 512'(w);
    end
    issue(msg, 1'b1, 0);
    respond(dig_a, 1);
    #2;
    chk("v2_no_output", v_o, 1'b0);
    chk("v2_back_to_fill", ready_o, 1'b1);
    chk("v2_first_cleared", core_first_o, 1'b0);
    cyc();
    msg = '0;
    for (int i = 0; i < 16; i++) begin
      w = 32'h20000000 + i;
      send_word(w, (i == 15));
      msg = (msg << 32) | 512'(w);
    end
    issue(msg, 1'b0, 0);
    respond(dig_b, 0);
    drain(dig_b, 1'b0);
    chk("v2_core_yumi_pulses", 512'(yumi_cnt - y0), 512'd2);
    chk("v2_out_words", 512'(out_cnt - o0), 512'd8);
    cyc();

    // V-3: core stalls in ISSUE, consumer takes every other cycle
    msg = '0;
    for (int i = 0; i < 16; i++) begin
      w = 32'h30000000 + 32'(i * 7);
      send_word(w, 1'b1);
      msg = (msg << 32) | 512'(w);
    end
    issue(msg, 1'b1, 5);
    respond(dig_a, 3);
    drain(dig_a, 1'b1);
    cyc();

    // V-4: enable dropped mid-block with v_i held
    msg = '0;
    for (int i = 16; i < 36; i++) begin
      apply_vec(i);
      if (tbl[i].exp_ready) msg = (msg << 32) | 512'(tbl[i].d);
    end
    issue(msg, 1'b1, 0);
    respond(dig_b, 1);
    drain(dig_b, 1'b0);
    cyc();

    // V-6: v_i held through BUSY and DRAIN is only taken once FILL resumes
    msg = '0;
    for (int i = 0; i < 16; i++) begin
      w = 32'h60000000 + i;
      send_word(w, 1'b1);
      msg = (msg << 32) | 512'(w);
    end
    issue(msg, 1'b1, 0);
    v_i = 1'b1; data_i = 32'hDEADBEEF;
    respond(dig_abc, 2);
    drain(dig_abc, 1'b0);
    cyc();
    v_i = 1'b0;
    msg = 512'(32'hDEADBEEF);
    for (int i = 1; i < 16; i++) begin
      w = 32'h66000000 + i;
      send_word(w, 1'b0);
      msg = (msg << 32) | 512'(w);
    end
    issue(msg, 1'b1, 0);
    respond(dig_a, 0);
    #2;
    chk("v6_first_cleared", core_first_o, 1'b0);
    cyc();

    // V-5: asynchronous reset mid-block
    for (int i = 0; i < 10; i++) send_word(32'h50000000 + i, 1'b1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("v5_rst_ready", ready_o, 1'b0);
    chk("v5_rst_msg", core_msg_o, '0);
    chk("v5_rst_first", core_first_o, 1'b1);
    chk("v5_rst_v_o", v_o, 1'b0);
    chk("v5_rst_core_v", core_v_o, 1'b0);
    cyc();
    reset_i = 1'b0;
    msg = '0;
    for (int i = 0; i < 16; i++) begin
      w = 32'h55000000 + i;
      send_word(w, (i == 15));
      msg = (msg << 32) | 512'(w);
    end
    issue(msg, 1'b1, 0);
    respond(dig_b, 1);
    drain(dig_b, 1'b1);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
